// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK levels, R/W bit values.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        WAIT_STOP
    } state_e;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Bus and local byte-port signals of the I2C target.
interface i2c_slave_responder_if;
    import i2c_pkg::*;

    logic              scl_in;
    logic              sda_in;
    logic              sda_out;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_load;
    logic              busy;
    logic              addr_hit;

    modport slave (
        input  scl_in, sda_in, rx_ready, tx_data,
        output sda_out, rx_data, rx_valid, tx_load, busy, addr_hit
    );

    modport master (
        output scl_in, sda_in, rx_ready, tx_data,
        input  sda_out, rx_data, rx_valid, tx_load, busy, addr_hit
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Idle bus reads high, so the chains reset to 1 to avoid false edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: 7-bit address match, write bytes to rx port, read bytes from tx port.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h01,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    i2c_slave_responder_if.slave  bus
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  shift_q, shift_d;
    logic [BYTE_W-1:0]  tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0]  rx_data_q, rx_data_d;
    logic               rw_q, rw_d;
    logic               ack_due_q, ack_due_d;
    logic               sda_q, sda_d;
    logic               busy_q, busy_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_load_q, tx_load_d;
    logic               addr_hit_q, addr_hit_d;
    logic               load_tx;
    logic [BYTE_W-1:0]  in_byte;

    assign in_byte = {shift_q[BYTE_W-2:0], sda_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        ack_due_d  = ack_due_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        addr_hit_d = 1'b0;
        load_tx    = 1'b0;

        // Bus conditions override everything, including an ACK we are driving.
        if (stop_det) begin
            state_d   = IDLE;
            sda_d     = NACK;
            busy_d    = 1'b0;
            cnt_d     = '0;
            ack_due_d = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_d     = NACK;
            cnt_d     = '0;
            ack_due_d = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise && !ack_due_q) begin
                        shift_d = in_byte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (in_byte[7:1] == SLAVE_ADDR) begin
                                addr_hit_d = 1'b1;
                                busy_d     = 1'b1;
                                rw_d       = in_byte[0];
                                ack_due_d  = 1'b1;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && ack_due_q) begin
                        ack_due_d = 1'b0;
                        sda_d     = ACK;
                        state_d   = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q == RW_WRITE) begin
                            sda_d   = NACK;
                            cnt_d   = '0;
                            state_d = RX_DATA;
                        end else begin
                            load_tx = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise && !ack_due_q) begin
                        shift_d = in_byte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) ack_due_d = 1'b1;
                    end else if (scl_fall && ack_due_q) begin
                        ack_due_d = 1'b0;
                        if (bus.rx_ready) begin
                            sda_d      = ACK;
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = RX_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_d   = NACK;
                        state_d = RX_DATA;
                    end
                end
                TX_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_d   = NACK;
                            cnt_d   = '0;
                            state_d = TX_ACK;
                        end else begin
                            sda_d      = tx_shift_q[BYTE_W-1];
                            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
                            cnt_d      = cnt_q + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == ACK) begin
                            ack_due_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && ack_due_q) begin
                        ack_due_d = 1'b0;
                        load_tx   = 1'b1;
                    end
                end
                default: begin
                    sda_d = NACK;
                end
            endcase
        end

        // MSB goes out on the same edge that captures the new byte.
        if (load_tx) begin
            tx_load_d  = 1'b1;
            sda_d      = bus.tx_data[BYTE_W-1];
            tx_shift_d = {bus.tx_data[BYTE_W-2:0], 1'b0};
            cnt_d      = '0;
            state_d    = TX_DATA;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rw_q       <= RW_WRITE;
            ack_due_q  <= 1'b0;
            sda_q      <= NACK;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            addr_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            ack_due_q  <= ack_due_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            addr_hit_q <= addr_hit_d;
        end
    end

    assign bus.sda_out  = sda_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_load  = tx_load_q;
    assign bus.busy     = busy_q;
    assign bus.addr_hit = addr_hit_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master against i2c_slave_responder with a wired-AND SDA line.
module tb_i2c_slave_responder;
    import i2c_pkg::*;

    localparam int unsigned H = 8;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;

    int total = 0;
    int bad   = 0;
    int n_hit = 0;
    int n_rxv = 0;
    int n_txl = 0;
    int n_low = 0;
    logic [7:0] rx_log [$];

    i2c_slave_responder_if bus ();

    assign bus.scl_in   = m_scl;
    assign bus.sda_in   = m_sda & bus.sda_out;
    assign bus.rx_ready = rx_ready;
    assign bus.tx_data  = tx_data;

    i2c_slave_responder #(.SLAVE_ADDR(7'h01), .SYNC_STAGES(2)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (bus.addr_hit) n_hit++;
        if (bus.tx_load)  n_txl++;
        if (bus.sda_out == 1'b0) n_low++;
        if (bus.rx_valid) begin
            n_rxv++;
            rx_log.push_back(bus.rx_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic clock_bit(input logic b, output logic sampled);
        m_sda = b;
        wait_cyc(H);
        m_scl = 1'b1;
        wait_cyc(H);
        sampled = bus.sda_in;
        m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_cyc(H);
        m_scl = 1'b1;
        wait_cyc(H);
        m_sda = 1'b0;
        wait_cyc(H);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_cyc(H);
        m_scl = 1'b1;
        wait_cyc(H);
        m_sda = 1'b1;
        wait_cyc(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(master_ack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         h0, r0, t0, l0;

        // reset values
        wait_cyc(3);
        chk("rst_sda", 32'(bus.sda_out), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rxdata", 32'(bus.rx_data), 32'h00);
        PRESETn = 1'b1;
        wait_cyc(4);

        // write 0x02, 0x11, 0x22
        i2c_start();
        write_byte(8'h02, ack);  chk("w_addr_ack", 32'(ack), 32'd0);
        chk("w_hit", 32'(n_hit), 32'd1);
        chk("w_busy", 32'(bus.busy), 32'd1);
        write_byte(8'h11, ack);  chk("w_b1_ack", 32'(ack), 32'd0);
        write_byte(8'h22, ack);  chk("w_b2_ack", 32'(ack), 32'd0);
        wait_cyc(4);
        chk("w_nrxv", 32'(n_rxv), 32'd2);
        chk("w_log0", 32'(rx_log[0]), 32'h11);
        chk("w_log1", 32'(rx_log[1]), 32'h22);
        chk("w_rxdata", 32'(bus.rx_data), 32'h22);
        i2c_stop();
        chk("w_busy_end", 32'(bus.busy), 32'd0);
        chk("w_sda_end", 32'(bus.sda_out), 32'd1);

        // address mismatch 0x9E
        h0 = n_hit; r0 = n_rxv; l0 = n_low;
        i2c_start();
        write_byte(8'h9E, ack);  chk("m_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h11, ack);  chk("m_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        chk("m_no_low", 32'(n_low - l0), 32'd0);
        chk("m_no_hit", 32'(n_hit - h0), 32'd0);
        chk("m_no_rxv", 32'(n_rxv - r0), 32'd0);
        chk("m_busy", 32'(bus.busy), 32'd0);

        // read 0x03: 0xA5 (master ACK), then 0x3C (master NACK)
        tx_data = 8'hA5;
        t0 = n_txl;
        i2c_start();
        write_byte(8'h03, ack);  chk("r_addr_ack", 32'(ack), 32'd0);
        wait_cyc(H / 2);
        chk("r_txl1", 32'(n_txl - t0), 32'd1);
        tx_data = 8'h3C;
        read_byte(1'b0, d);      chk("r_byte1", 32'(d), 32'hA5);
        chk("r_busy_mid", 32'(bus.busy), 32'd1);
        read_byte(1'b1, d);      chk("r_byte2", 32'(d), 32'h3C);
        wait_cyc(H / 2);
        chk("r_txl2", 32'(n_txl - t0), 32'd2);
        chk("r_sda_rel", 32'(bus.sda_out), 32'd1);
        chk("r_busy_nack", 32'(bus.busy), 32'd0);
        chk("r_state", 32'(dut.state_q), 32'(WAIT_STOP));
        i2c_stop();

        // rx_ready low: data NACK, no rx_valid
        r0 = n_rxv;
        i2c_start();
        write_byte(8'h02, ack);  chk("n_addr_ack", 32'(ack), 32'd0);
        rx_ready = 1'b0;
        write_byte(8'h55, ack);  chk("n_data_nack", 32'(ack), 32'd1);
        chk("n_state", 32'(dut.state_q), 32'(WAIT_STOP));
        rx_ready = 1'b1;
        write_byte(8'h66, ack);  chk("n_still_nack", 32'(ack), 32'd1);
        chk("n_state2", 32'(dut.state_q), 32'(WAIT_STOP));
        chk("n_no_rxv", 32'(n_rxv - r0), 32'd0);
        i2c_stop();
        chk("n_idle", 32'(dut.state_q), 32'(IDLE));

        // write 0x11, repeated START, read 0x99
        h0 = n_hit;
        tx_data = 8'h99;
        i2c_start();
        write_byte(8'h02, ack);  chk("s_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h11, ack);  chk("s_b_ack", 32'(ack), 32'd0);
        i2c_start();
        wait_cyc(4);
        chk("s_busy_rs", 32'(bus.busy), 32'd1);
        write_byte(8'h03, ack);  chk("s_raddr_ack", 32'(ack), 32'd0);
        chk("s_hits", 32'(n_hit - h0), 32'd2);
        read_byte(1'b1, d);      chk("s_rbyte", 32'(d), 32'h99);
        chk("s_rxdata", 32'(bus.rx_data), 32'h11);
        i2c_stop();
        chk("s_busy_end", 32'(bus.busy), 32'd0);

        // async reset while driving address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'h02;
            clock_bit(d[i], s);
        end
        wait_cyc(H / 2 + 2);
        chk("a_ack_low", 32'(bus.sda_out), 32'd0);
        #2 PRESETn = 1'b0;
        #1 chk("a_sda_async", 32'(bus.sda_out), 32'd1);
        wait_cyc(2);
        chk("a_busy", 32'(bus.busy), 32'd0);
        chk("a_rxdata", 32'(bus.rx_data), 32'h00);
        chk("a_pulses", 32'({bus.rx_valid, bus.tx_load, bus.addr_hit}), 32'd0);
        chk("a_state", 32'(dut.state_q), 32'(IDLE));
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_cyc(4);
        PRESETn = 1'b1;
        wait_cyc(4);
        r0 = n_rxv;
        i2c_start();
        write_byte(8'h02, ack);  chk("a2_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h5A, ack);  chk("a2_b_ack", 32'(ack), 32'd0);
        wait_cyc(4);
        chk("a2_rxdata", 32'(bus.rx_data), 32'h5A);
        chk("a2_rxv", 32'(n_rxv - r0), 32'd1);
        i2c_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (slave) that answers the APB-controlled I2C master on the same bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then receives write bytes to a local byte port, or returns bytes from that port on reads.
- Used as the far-end bus model in system simulation and as a synthesizable target in loop-back builds.

Parameters:
- SLAVE_ADDR, 7'h01, 7-bit address this target answers to.
- SYNC_STAGES, 2, synchronizer depth on scl_in and sda_in; legal range 2 to 3.

Ports:
- PCLK  in  1  system clock; all logic is on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- scl_in  in  1  bus SCL level.
- sda_in  in  1  bus SDA level.
- sda_out  out  1  open-drain SDA control: 0 pulls low, 1 releases.
- rx_data  out  8  last received write byte; holds until the next byte.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_ready  in  1  local side can accept a byte; sampled at the ACK decision.
- tx_data  in  8  byte to return on a read; sampled when tx_load is high.
- tx_load  out  1  one-cycle pulse; tx_data is captured this cycle.
- busy  out  1  high from an address match until STOP or NACK-out.
- addr_hit  out  1  one-cycle pulse on an address match.

Behaviour:
- Reset: sda_out=1, rx_data=0, rx_valid=0, tx_load=0, busy=0, addr_hit=0, state=IDLE, bit counter=0. Reset mid-transfer releases SDA immediately, with no partial byte delivered.
- Sync and edge detection:
  - scl_s/sda_s are the SYNC_STAGES-flop copies of the inputs; previous values are registered.
  - scl_rise/scl_fall come from scl_s transitions.
  - START = sda_s falls while scl_s is high. STOP = sda_s rises while scl_s is high.
  - START/STOP take priority over data sampling in the same cycle.
- Sampling and driving:
  - Data is sampled on the scl_rise cycle.
  - sda_out changes only on the scl_fall cycle, registered, one PCLK after the synchronized edge.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- IDLE: on START go to ADDR with the bit counter at 0.
- ADDR:
  - Shift 8 bits MSB first.
  - After bit 8, if [7:1]==SLAVE_ADDR: pulse addr_hit, set busy, and on the next scl_fall drive sda_out=0, then go to ADDR_ACK.
  - On mismatch go to WAIT_STOP with SDA released.
- ADDR_ACK:
  - At the scl_fall ending the ACK clock, when R/W=0: release SDA and go to RX_DATA.
  - When R/W=1: pulse tx_load, capture tx_data, drive its MSB on that same scl_fall, and go to TX_DATA.
- RX_DATA:
  - Shift 8 bits.
  - After bit 8, at the next scl_fall: if rx_ready=1, drive ACK (0), update rx_data and pulse rx_valid, then go to RX_ACK.
  - If rx_ready=0, keep SDA released (NACK), drop the byte, and go to WAIT_STOP.
- RX_ACK: at scl_fall release SDA and go to RX_DATA.
- TX_DATA:
  - Shift out on each scl_fall.
  - After bit 8 has been clocked, at its scl_fall release SDA and go to TX_ACK.
- TX_ACK:
  - Sample SDA at scl_rise.
  - If 0 (master ACK): at the next scl_fall pulse tx_load, load tx_data, drive its MSB, and go to TX_DATA.
  - If 1 (NACK): clear busy and go to WAIT_STOP.
- WAIT_STOP: SDA released; wait for STOP or START.
- From any state:
  - STOP: go to IDLE, sda_out=1, busy=0.
  - START (repeated): go to ADDR, sda_out=1, counter=0. busy stays high until the address phase resolves, then follows the new match.
- A START or STOP seen while SDA is driven low by this block cannot be a legal bus event. It is still honoured: release SDA.
- Bit counter is 3 bits, wraps 7 to 0 at each byte end; 9th clock is the ACK slot.
- No clock stretching: SCL is never driven.
- Minimum supported ratio: SCL high and low phases each at least SYNC_STAGES+3 PCLK cycles.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum constants;
  - ACK=1'b0 and NACK=1'b1;
  - the RW_READ/RW_WRITE bit values.
- One natural sub-module, i2c_bus_sync: synchronizers plus scl_rise, scl_fall, start_det and stop_det, for reuse by the master side.

Test Plan:
- Write 0x02 then bytes 0x11, 0x22, then STOP, rx_ready=1 -> addr_hit pulse; ACK low on 3 ACK slots; rx_valid pulses with rx_data 0x11 then 0x22; busy drops after STOP; sda_out=1.
- Address 0x4F<<1 with SLAVE_ADDR=0x01 -> no ACK (sda_out stays 1 the whole frame); no addr_hit/rx_valid; busy=0.
- Read 0x03, tx_data=0xA5 then 0x3C, master ACKs byte 1 and NACKs byte 2 -> SDA bits 10100101 then 00111100; tx_load pulses twice; SDA released after NACK; busy=0.
- Write 0x02, byte 0x55 with rx_ready=0 -> 9th clock SDA high (NACK); no rx_valid; state WAIT_STOP until STOP.
- Write 0x02, byte 0x11, repeated START, read 0x03 with tx_data=0x99 -> rx_data=0x11; second addr_hit; 0x99 driven; busy held high across the repeated START.
- PRESETn low while driving ACK low mid-frame -> sda_out=1 immediately (asynchronous); all outputs at reset values; next START decodes normally.
